// File: rtl/ls_pkg.sv
// Shared constants and encodings for the load/store queue.
// Width defaults here seed the parameters of every ls_queue file.
package ls_pkg;

    localparam int DEPTH_DEF   = 16;
    localparam int TAG_W_DEF   = 5;
    localparam int NUM_CDB_DEF = 2;
    localparam int OP_W_DEF    = 6;
    localparam int XLEN_DEF    = 32;

    // ROB tag 0 means "operand already available"
    localparam int TAG_ZERO = 0;

    typedef enum logic [5:0] {
        OP_LB  = 6'h00,
        OP_LH  = 6'h01,
        OP_LW  = 6'h02,
        OP_LBU = 6'h04,
        OP_LHU = 6'h05,
        OP_SB  = 6'h08,
        OP_SH  = 6'h09,
        OP_SW  = 6'h0A
    } ls_op_e;

endpackage

// File: rtl/ls_queue_if.sv
// Dispatch, issue, CDB and commit bundle of the load/store queue.
// The core side drives as master, the queue sits on the slave modport.
interface ls_queue_if import ls_pkg::*; #(
    parameter int DEPTH   = DEPTH_DEF,
    parameter int TAG_W   = TAG_W_DEF,
    parameter int NUM_CDB = NUM_CDB_DEF,
    parameter int OP_W    = OP_W_DEF,
    parameter int XLEN    = XLEN_DEF
) ();

    logic                    disp_valid;
    logic                    disp_is_store;
    logic [OP_W-1:0]         disp_op;
    logic [XLEN-1:0]         disp_v1;
    logic [XLEN-1:0]         disp_v2;
    logic [XLEN-1:0]         disp_imm;
    logic [TAG_W-1:0]        disp_q1;
    logic [TAG_W-1:0]        disp_q2;
    logic [TAG_W-1:0]        disp_tag;
    logic                    full;
    logic [$clog2(DEPTH):0]  count;
    logic                    ex_valid;
    logic [OP_W-1:0]         ex_op;
    logic [XLEN-1:0]         ex_addr;
    logic [XLEN-1:0]         ex_data;
    logic [TAG_W-1:0]        ex_tag;
    logic                    ex_busy;
    logic [NUM_CDB-1:0]      cdb_valid;
    logic [NUM_CDB*TAG_W-1:0] cdb_tag;
    logic [NUM_CDB*XLEN-1:0] cdb_data;
    logic                    commit_valid;
    logic [TAG_W-1:0]        commit_tag;
    logic                    st_ready_valid;
    logic [TAG_W-1:0]        st_ready_tag;
    logic                    flush;

    modport master (
        output disp_valid, disp_is_store, disp_op,
        output disp_v1, disp_v2, disp_imm,
        output disp_q1, disp_q2, disp_tag,
        output ex_busy, cdb_valid, cdb_tag, cdb_data,
        output commit_valid, commit_tag, flush,
        input  full, count, ex_valid, ex_op,
        input  ex_addr, ex_data, ex_tag,
        input  st_ready_valid, st_ready_tag
    );

    modport slave (
        input  disp_valid, disp_is_store, disp_op,
        input  disp_v1, disp_v2, disp_imm,
        input  disp_q1, disp_q2, disp_tag,
        input  ex_busy, cdb_valid, cdb_tag, cdb_data,
        input  commit_valid, commit_tag, flush,
        output full, count, ex_valid, ex_op,
        output ex_addr, ex_data, ex_tag,
        output st_ready_valid, st_ready_tag
    );

endinterface

// File: rtl/lsq_wakeup.sv
// Matches one pending operand tag against all CDB channels.
// Lowest-numbered channel wins if several carry the same tag.
module lsq_wakeup import ls_pkg::*; #(
    parameter int TAG_W   = TAG_W_DEF,
    parameter int NUM_CDB = NUM_CDB_DEF,
    parameter int XLEN    = XLEN_DEF
) (
    input  logic [TAG_W-1:0]         q_i,
    input  logic [NUM_CDB-1:0]       cdb_valid_i,
    input  logic [NUM_CDB*TAG_W-1:0] cdb_tag_i,
    input  logic [NUM_CDB*XLEN-1:0]  cdb_data_i,
    output logic                     match_o,
    output logic [XLEN-1:0]          data_o
);

    always_comb begin
        match_o = 1'b0;
        data_o  = '0;
        for (int k = NUM_CDB - 1; k >= 0; k--) begin
            if (cdb_valid_i[k] && q_i != TAG_W'(TAG_ZERO) &&
                cdb_tag_i[k*TAG_W +: TAG_W] == q_i) begin
                match_o = 1'b1;
                data_o  = cdb_data_i[k*XLEN +: XLEN];
            end
        end
    end

endmodule

// File: rtl/ls_queue.sv
// In-order load/store queue: CDB operand capture, head-only issue,
// store commit handshake with the ROB and flush rollback.
module ls_queue import ls_pkg::*; #(
    parameter int DEPTH   = DEPTH_DEF,
    parameter int TAG_W   = TAG_W_DEF,
    parameter int NUM_CDB = NUM_CDB_DEF,
    parameter int OP_W    = OP_W_DEF,
    parameter int XLEN    = XLEN_DEF
) (
    input  logic      clk,
    input  logic      rst,
    ls_queue_if.slave bus
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam logic [TAG_W-1:0] TZ = TAG_W'(TAG_ZERO);

    logic [PW-1:0]    head_q, head_d, tail_q, tail_d, cnt, keep;
    logic [AW-1:0]    hidx, tidx, kidx;
    logic             krun;
    logic [DEPTH-1:0] st_q, cmt_q, vld;
    logic [OP_W-1:0]  op_q  [DEPTH];
    logic [XLEN-1:0]  v1_q  [DEPTH];
    logic [XLEN-1:0]  v2_q  [DEPTH];
    logic [XLEN-1:0]  imm_q [DEPTH];
    logic [TAG_W-1:0] q1_q  [DEPTH];
    logic [TAG_W-1:0] q2_q  [DEPTH];
    logic [TAG_W-1:0] tag_q [DEPTH];

    logic [DEPTH-1:0] w1_hit, w2_hit;
    logic [XLEN-1:0]  w1_data [DEPTH];
    logic [XLEN-1:0]  w2_data [DEPTH];
    logic             d1_hit, d2_hit;
    logic [XLEN-1:0]  d1_data, d2_data;

    logic empty, full, head_rdy, issue, disp_ok, cmt_head, st_rdy;

    logic             ex_valid_q, srv_q;
    logic [OP_W-1:0]  ex_op_q;
    logic [XLEN-1:0]  ex_addr_q, ex_data_q;
    logic [TAG_W-1:0] ex_tag_q, srt_q;

    assign hidx  = head_q[AW-1:0];
    assign tidx  = tail_q[AW-1:0];
    assign cnt   = tail_q - head_q;
    assign empty = (cnt == '0);
    assign full  = (cnt == PW'(DEPTH));

    assign head_rdy = !empty && q1_q[hidx] == TZ && q2_q[hidx] == TZ;
    assign issue    = head_rdy && !bus.ex_busy &&
                      (!st_q[hidx] || cmt_q[hidx]);
    assign disp_ok  = bus.disp_valid && !full && !bus.flush;
    assign cmt_head = bus.commit_valid && bus.commit_tag == tag_q[hidx];
    // a commit arriving now ends the st_ready request
    assign st_rdy   = head_rdy && st_q[hidx] && !cmt_q[hidx] &&
                      !cmt_head && !bus.flush;

    for (genvar e = 0; e < DEPTH; e++) begin : g_ent
        logic [AW-1:0] off;
        assign off    = AW'(e) - hidx;
        assign vld[e] = {1'b0, off} < cnt;

        lsq_wakeup #(.TAG_W(TAG_W), .NUM_CDB(NUM_CDB), .XLEN(XLEN)) u_w1 (
            .q_i(q1_q[e]), .cdb_valid_i(bus.cdb_valid),
            .cdb_tag_i(bus.cdb_tag), .cdb_data_i(bus.cdb_data),
            .match_o(w1_hit[e]), .data_o(w1_data[e])
        );
        lsq_wakeup #(.TAG_W(TAG_W), .NUM_CDB(NUM_CDB), .XLEN(XLEN)) u_w2 (
            .q_i(q2_q[e]), .cdb_valid_i(bus.cdb_valid),
            .cdb_tag_i(bus.cdb_tag), .cdb_data_i(bus.cdb_data),
            .match_o(w2_hit[e]), .data_o(w2_data[e])
        );
    end

    lsq_wakeup #(.TAG_W(TAG_W), .NUM_CDB(NUM_CDB), .XLEN(XLEN)) u_d1 (
        .q_i(bus.disp_q1), .cdb_valid_i(bus.cdb_valid),
        .cdb_tag_i(bus.cdb_tag), .cdb_data_i(bus.cdb_data),
        .match_o(d1_hit), .data_o(d1_data)
    );
    lsq_wakeup #(.TAG_W(TAG_W), .NUM_CDB(NUM_CDB), .XLEN(XLEN)) u_d2 (
        .q_i(bus.disp_q2), .cdb_valid_i(bus.cdb_valid),
        .cdb_tag_i(bus.cdb_tag), .cdb_data_i(bus.cdb_data),
        .match_o(d2_hit), .data_o(d2_data)
    );

    // committed stores contiguous from head survive a flush
    always_comb begin
        keep = '0;
        krun = 1'b1;
        kidx = '0;
        for (int i = 0; i < DEPTH; i++) begin
            kidx = hidx + AW'(i);
            if (krun && PW'(i) < cnt && st_q[kidx] && cmt_q[kidx])
                keep = keep + PW'(1);
            else
                krun = 1'b0;
        end
    end

    always_comb begin
        head_d = head_q + PW'(issue);
        tail_d = tail_q + PW'(disp_ok);
        if (bus.flush)
            tail_d = head_q + ((issue && keep == '0) ? PW'(1) : keep);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q     <= '0;
            tail_q     <= '0;
            st_q       <= '0;
            cmt_q      <= '0;
            ex_valid_q <= 1'b0;
            ex_op_q    <= '0;
            ex_addr_q  <= '0;
            ex_data_q  <= '0;
            ex_tag_q   <= '0;
            srv_q      <= 1'b0;
            srt_q      <= '0;
            for (int e = 0; e < DEPTH; e++) begin
                q1_q[e] <= TZ;
                q2_q[e] <= TZ;
            end
        end else begin
            head_q     <= head_d;
            tail_q     <= tail_d;
            ex_valid_q <= issue;
            if (issue) begin
                ex_op_q   <= op_q[hidx];
                ex_addr_q <= v1_q[hidx] + imm_q[hidx];
                ex_data_q <= st_q[hidx] ? v2_q[hidx] : '0;
                ex_tag_q  <= tag_q[hidx];
            end
            srv_q <= st_rdy;
            srt_q <= st_rdy ? tag_q[hidx] : TZ;
            for (int e = 0; e < DEPTH; e++) begin
                if (vld[e] && w1_hit[e]) begin
                    v1_q[e] <= w1_data[e];
                    q1_q[e] <= TZ;
                end
                if (vld[e] && w2_hit[e]) begin
                    v2_q[e] <= w2_data[e];
                    q2_q[e] <= TZ;
                end
                if (vld[e] && st_q[e] && bus.commit_valid &&
                    bus.commit_tag != TZ && bus.commit_tag == tag_q[e])
                    cmt_q[e] <= 1'b1;
            end
            if (disp_ok) begin
                op_q[tidx]  <= bus.disp_op;
                st_q[tidx]  <= bus.disp_is_store;
                cmt_q[tidx] <= 1'b0;
                imm_q[tidx] <= bus.disp_imm;
                tag_q[tidx] <= bus.disp_tag;
                v1_q[tidx]  <= d1_hit ? d1_data : bus.disp_v1;
                q1_q[tidx]  <= d1_hit ? TZ : bus.disp_q1;
                v2_q[tidx]  <= d2_hit ? d2_data : bus.disp_v2;
                q2_q[tidx]  <= d2_hit ? TZ : bus.disp_q2;
            end
        end
    end

    assign bus.full           = full;
    assign bus.count          = cnt;
    assign bus.ex_valid       = ex_valid_q;
    assign bus.ex_op          = ex_op_q;
    assign bus.ex_addr        = ex_addr_q;
    assign bus.ex_data        = ex_data_q;
    assign bus.ex_tag         = ex_tag_q;
    assign bus.st_ready_valid = srv_q;
    assign bus.st_ready_tag   = srt_q;

endmodule

// File: tb/tb_ls_queue.sv
// Directed and random checks of ls_queue against a queue-based model.
module tb_ls_queue;
    import ls_pkg::*;

    localparam int DEPTH = 16, TAG_W = 5, NUM_CDB = 2, OP_W = 6, XLEN = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;

    ls_queue_if #(.DEPTH(DEPTH), .TAG_W(TAG_W), .NUM_CDB(NUM_CDB),
                  .OP_W(OP_W), .XLEN(XLEN)) bus ();

    ls_queue #(.DEPTH(DEPTH), .TAG_W(TAG_W), .NUM_CDB(NUM_CDB),
               .OP_W(OP_W), .XLEN(XLEN)) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp,
                     $time);
        end
    endtask

    typedef struct {
        bit          st;
        bit          cmt;
        logic [5:0]  op;
        logic [31:0] v1, v2, imm;
        logic [4:0]  q1, q2, tag;
    } ment_t;

    ment_t       mq[$];
    logic        e_exv, e_srv;
    logic [4:0]  e_tag, e_srt;
    logic [5:0]  e_op;
    logic [31:0] e_addr, e_data;
    int          e_cnt;

    function automatic logic [36:0] resolve(logic [4:0] q, logic [31:0] v);
        for (int k = 0; k < NUM_CDB; k++)
            if (q != 0 && bus.cdb_valid[k] &&
                bus.cdb_tag[k*TAG_W +: TAG_W] == q)
                return {5'd0, bus.cdb_data[k*XLEN +: XLEN]};
        return {q, v};
    endfunction

    // reference: an ordered list of entries, the front one issues
    always @(posedge clk) begin
        ment_t       h, n;
        bit          iss, rdy, was_full;
        int          keep;
        logic [36:0] r;
        if (rst) begin
            mq.delete();
            e_exv = 0; e_srv = 0; e_srt = 0; e_cnt = 0;
            e_tag = 0; e_op = 0; e_addr = 0; e_data = 0;
            chk_en = 1'b1;
        end else begin
            iss = 0;
            e_srv = 0;
            e_srt = 0;
            was_full = (mq.size() == DEPTH);
            if (mq.size() > 0) begin
                h = mq[0];
                rdy = (h.q1 == 0 && h.q2 == 0);
                iss = rdy && !bus.ex_busy && (!h.st || h.cmt);
                e_srv = rdy && h.st && !h.cmt && !bus.flush &&
                        !(bus.commit_valid && bus.commit_tag == h.tag);
                e_srt = e_srv ? h.tag : 5'd0;
                if (iss) begin
                    e_addr = h.v1 + h.imm;
                    e_data = h.st ? h.v2 : 32'd0;
                    e_tag  = h.tag;
                    e_op   = h.op;
                end
            end
            e_exv = iss;
            keep = 0;
            while (keep < mq.size() && mq[keep].st && mq[keep].cmt) keep++;
            foreach (mq[i]) begin
                r = resolve(mq[i].q1, mq[i].v1);
                mq[i].q1 = r[36:32];
                mq[i].v1 = r[31:0];
                r = resolve(mq[i].q2, mq[i].v2);
                mq[i].q2 = r[36:32];
                mq[i].v2 = r[31:0];
                if (bus.commit_valid && mq[i].st && mq[i].tag == bus.commit_tag)
                    mq[i].cmt = 1;
            end
            if (bus.flush)
                while (mq.size() > keep) void'(mq.pop_back());
            if (iss && mq.size() > 0) void'(mq.pop_front());
            if (bus.disp_valid && !bus.flush && !was_full) begin
                n.st = bus.disp_is_store;
                n.cmt = 0;
                n.op = bus.disp_op;
                n.imm = bus.disp_imm;
                n.tag = bus.disp_tag;
                r = resolve(bus.disp_q1, bus.disp_v1);
                n.q1 = r[36:32];
                n.v1 = r[31:0];
                r = resolve(bus.disp_q2, bus.disp_v2);
                n.q2 = r[36:32];
                n.v2 = r[31:0];
                mq.push_back(n);
            end
            e_cnt = mq.size();
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("ex_valid", bus.ex_valid, e_exv);
            chk("st_ready_valid", bus.st_ready_valid, e_srv);
            chk("count", bus.count, e_cnt);
            chk("full", bus.full, e_cnt == DEPTH);
            if (e_exv) begin
                chk("ex_addr", bus.ex_addr, e_addr);
                chk("ex_data", bus.ex_data, e_data);
                chk("ex_tag", bus.ex_tag, e_tag);
                chk("ex_op", bus.ex_op, e_op);
            end
            if (e_srv) chk("st_ready_tag", bus.st_ready_tag, e_srt);
        end
    end

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle();
        bus.disp_valid = 0; bus.disp_is_store = 0; bus.disp_op = 0;
        bus.disp_v1 = 0; bus.disp_v2 = 0; bus.disp_imm = 0;
        bus.disp_q1 = 0; bus.disp_q2 = 0; bus.disp_tag = 0;
        bus.ex_busy = 0; bus.cdb_valid = 0; bus.cdb_tag = 0;
        bus.cdb_data = 0; bus.commit_valid = 0; bus.commit_tag = 0;
        bus.flush = 0;
    endtask

    task automatic disp(input bit st, input logic [4:0] tag,
                        input logic [31:0] v1, input logic [31:0] v2,
                        input logic [31:0] imm, input logic [4:0] q1,
                        input logic [4:0] q2);
        bus.disp_valid = 1; bus.disp_is_store = st;
        bus.disp_op = st ? OP_SW : OP_LW;
        bus.disp_v1 = v1; bus.disp_v2 = v2; bus.disp_imm = imm;
        bus.disp_q1 = q1; bus.disp_q2 = q2; bus.disp_tag = tag;
    endtask

    task automatic fill_drain(input logic [31:0] base);
        logic [31:0] got[$];
        idle();
        bus.ex_busy = 1;
        for (int i = 0; i < DEPTH; i++) begin
            disp(0, 5'(i + 1), base + 32'(i * 16), 0, 0, 0, 0);
            cyc();
        end
        chk("fill_full", bus.full, 1);
        chk("fill_count", bus.count, DEPTH);
        disp(0, 5'd20, 32'hBAD0, 0, 0, 0, 0);
        cyc();
        chk("overflow_ignored", bus.count, DEPTH);
        idle();
        for (int c = 0; c < DEPTH + 4; c++) begin
            cyc();
            if (bus.ex_valid) got.push_back(bus.ex_addr);
        end
        chk("drain_n", got.size(), DEPTH);
        foreach (got[i]) chk("wrap_order", got[i], base + 32'(i * 16));
        chk("drain_count", bus.count, 0);
    endtask

    initial begin
        logic [4:0] tags[$];
        idle();
        rst = 1;
        cyc();
        cyc();
        chk("rst_count", bus.count, 0);
        chk("rst_full", bus.full, 0);
        chk("rst_ex_valid", bus.ex_valid, 0);
        chk("rst_ex_addr", bus.ex_addr, 0);
        chk("rst_st_ready", bus.st_ready_valid, 0);
        rst = 0;

        disp(0, 5'd1, 32'h100, 0, 32'h4, 0, 0);
        cyc();
        idle();
        cyc();
        chk("load_ex_valid", bus.ex_valid, 1);
        chk("load_ex_addr", bus.ex_addr, 32'h104);
        chk("load_ex_data", bus.ex_data, 0);
        cyc();
        chk("load_pulse", bus.ex_valid, 0);

        disp(1, 5'd3, 32'h200, 32'hDEADBEEF, 32'h8, 0, 0);
        cyc();
        idle();
        cyc();
        chk("st_ready_valid", bus.st_ready_valid, 1);
        chk("st_ready_tag", bus.st_ready_tag, 3);
        chk("store_wait", bus.ex_valid, 0);
        bus.commit_valid = 1;
        bus.commit_tag = 3;
        cyc();
        idle();
        chk("st_ready_drop", bus.st_ready_valid, 0);
        cyc();
        chk("store_ex_valid", bus.ex_valid, 1);
        chk("store_ex_addr", bus.ex_addr, 32'h208);
        chk("store_ex_data", bus.ex_data, 32'hDEADBEEF);

        disp(1, 5'd7, 32'hFFFF, 0, 32'h10, 5'd5, 5'd6);
        cyc();
        idle();
        bus.commit_valid = 1;
        bus.commit_tag = 7;
        cyc();
        idle();
        bus.cdb_valid = 2'b11;
        bus.cdb_tag = {5'd6, 5'd5};
        bus.cdb_data = {32'hB, 32'hA};
        cyc();
        idle();
        chk("dual_not_early", bus.ex_valid, 0);
        cyc();
        chk("dual_ex_valid", bus.ex_valid, 1);
        chk("dual_ex_addr", bus.ex_addr, 32'h1A);
        chk("dual_ex_data", bus.ex_data, 32'hB);

        fill_drain(32'h1000);
        fill_drain(32'h2000);

        idle();
        bus.ex_busy = 1;
        disp(1, 5'd10, 32'h300, 32'h11, 0, 0, 0); cyc();
        disp(1, 5'd11, 32'h310, 32'h22, 0, 0, 0); cyc();
        disp(0, 5'd12, 32'h320, 0, 0, 0, 0); cyc();
        disp(0, 5'd13, 32'h330, 0, 0, 0, 0); cyc();
        disp(0, 5'd14, 32'h340, 0, 0, 0, 0); cyc();
        idle();
        bus.ex_busy = 1;
        bus.commit_valid = 1;
        bus.commit_tag = 10;
        cyc();
        bus.commit_tag = 11;
        cyc();
        bus.commit_valid = 0;
        bus.flush = 1;
        cyc();
        chk("flush_count", bus.count, 2);
        idle();
        for (int c = 0; c < 8; c++) begin
            cyc();
            if (bus.ex_valid) tags.push_back(bus.ex_tag);
        end
        chk("flush_issued_n", tags.size(), 2);
        if (tags.size() == 2) begin
            chk("flush_first", tags[0], 10);
            chk("flush_second", tags[1], 11);
        end

        for (int c = 0; c < 3000; c++) begin
            bus.disp_valid = 1'($urandom_range(0, 1));
            bus.disp_is_store = 1'($urandom_range(0, 1));
            bus.disp_op = 6'($urandom);
            bus.disp_v1 = $urandom;
            bus.disp_v2 = $urandom;
            bus.disp_imm = $urandom;
            bus.disp_q1 = $urandom_range(0, 1) ? 5'd0 : 5'($urandom_range(1, 7));
            bus.disp_q2 = $urandom_range(0, 1) ? 5'd0 : 5'($urandom_range(1, 7));
            bus.disp_tag = 5'($urandom_range(1, 31));
            bus.ex_busy = ($urandom_range(0, 3) == 0);
            bus.cdb_valid = 2'($urandom_range(0, 3));
            bus.cdb_tag = {5'($urandom_range(1, 7)), 5'($urandom_range(1, 7))};
            bus.cdb_data = {$urandom, $urandom};
            bus.flush = ($urandom_range(0, 39) == 0);
            bus.commit_valid = !bus.flush && ($urandom_range(0, 2) == 0);
            bus.commit_tag = 5'd1;
            if (mq.size() > 0)
                bus.commit_tag = mq[$urandom_range(0, (mq.size() > 3) ? 2 :
                                                      mq.size() - 1)].tag;
            cyc();
        end

        disp(1, 5'd9, 32'h1, 32'h2, 32'h3, 0, 0);
        bus.commit_valid = 1;
        bus.flush = 1;
        rst = 1;
        cyc();
        chk("rst_override_count", bus.count, 0);
        chk("rst_override_ex", bus.ex_valid, 0);
        chk("rst_override_sr", bus.st_ready_valid, 0);
        rst = 0;
        idle();
        cyc();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
